// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the CPU's single memory port between the instruction-fetch path and
// the load/store data path. One request is issued at a time; ties between the
// two requesters are broken round-robin. Reads are tracked for the memory's
// fixed latency, and the returning data is steered to the requester that owns
// the outstanding read. Stores complete in their issue cycle.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   if_req/if_addr            fetch read request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata fetch grant and read-data return
//   d_req/d_wr/d_addr/d_wdata data request (load or store), held until d_gnt
//   d_gnt/d_rvalid/d_rdata    data grant and load-data return
//   mem_enable/mem_wr         memory access strobe and write strobe
//   mem_addr/mem_data_in      memory address and write data
//   mem_data_out              memory read data, valid MEM_LAT cycles after issue
//   conflict_cnt              saturating count of contended issue slots
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic [CNT_W-1:0]  conflict_cnt
);

   localparam int LAT_W = $clog2(MEM_LAT + 1);

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
   logic               owner_d_q, owner_d_d;     // 1: data path owns the read
   logic               last_d_q, last_d_d;       // 1: data path won the last grant
   logic [CNT_W-1:0]   conflict_cnt_q, conflict_cnt_d;

   logic               rd_done;
   logic               can_issue;
   logic               pick_d;

   // The final latency cycle doubles as an issue slot, so back-to-back reads
   // sustain one access per MEM_LAT cycles.
   assign rd_done   = (state_q == RD_WAIT) && (lat_cnt_q == LAT_W'(1));
   assign can_issue = (state_q == IDLE) || rd_done;

   // On a tie the requester that did not win last time gets the slot.
   assign pick_d    = d_req && (!if_req || !last_d_q);

   // NOTE: every signal written here gets a default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d        = state_q;
      lat_cnt_d      = lat_cnt_q;
      owner_d_d      = owner_d_q;
      last_d_d       = last_d_q;
      conflict_cnt_d = conflict_cnt_q;
      if_gnt         = 1'b0;
      if_rvalid      = 1'b0;
      if_rdata       = '0;
      d_gnt          = 1'b0;
      d_rvalid       = 1'b0;
      d_rdata        = '0;
      mem_enable     = 1'b0;
      mem_wr         = 1'b0;
      mem_addr       = '0;
      mem_data_in    = '0;

      if (state_q == RD_WAIT) begin
         lat_cnt_d = lat_cnt_q - 1'b1;
         if (rd_done) begin
            state_d = IDLE;
         end
      end

      // Read data is passed straight through to the owner only.
      if (rd_done) begin
         if (owner_d_q) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_data_out;
         end else begin
            if_rvalid = 1'b1;
            if_rdata  = mem_data_out;
         end
      end

      if (can_issue && (if_req || d_req)) begin
         mem_enable = 1'b1;
         last_d_d   = pick_d;
         if (pick_d) begin
            d_gnt    = 1'b1;
            mem_addr = d_addr;
            if (d_wr) begin
               // Stores finish in the issue cycle; the port stays free.
               mem_wr      = 1'b1;
               mem_data_in = d_wdata;
            end else begin
               state_d   = RD_WAIT;
               lat_cnt_d = LAT_W'(MEM_LAT);
               owner_d_d = 1'b1;
            end
         end else begin
            if_gnt    = 1'b1;
            mem_addr  = if_addr;
            state_d   = RD_WAIT;
            lat_cnt_d = LAT_W'(MEM_LAT);
            owner_d_d = 1'b0;
         end
      end

      if (can_issue && if_req && d_req && (conflict_cnt_q != '1)) begin
         conflict_cnt_d = conflict_cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from the same pre-edge snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         lat_cnt_q      <= '0;
         owner_d_q      <= 1'b0;
         last_d_q       <= 1'b1;
         conflict_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         lat_cnt_q      <= lat_cnt_d;
         owner_d_q      <= owner_d_d;
         last_d_q       <= last_d_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. Two instances share the stimulus:
// u_dut (MEM_LAT=1, CNT_W=4) for the directed vectors, counter saturation and
// randomized traffic; u_dut3 (MEM_LAT=3) for the longer-latency and
// reset-mid-read sequences. Inputs change on the falling edge and outputs are
// sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int OBS_W = 138;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        d_req = 1'b0;
   logic        d_wr = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] mem_data_out = '0;

   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_enable, mem_wr;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_data_in;
   logic [3:0]  conflict_cnt;

   logic        if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, mem_enable_3, mem_wr_3;
   logic [31:0] if_rdata_3, d_rdata_3, mem_addr_3, mem_data_in_3;
   logic [15:0] conflict_cnt_3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .conflict_cnt(conflict_cnt)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .CNT_W(16)) u_dut3 (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3),
      .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
      .mem_enable(mem_enable_3), .mem_wr(mem_wr_3), .mem_addr(mem_addr_3),
      .mem_data_in(mem_data_in_3), .mem_data_out(mem_data_out),
      .conflict_cnt(conflict_cnt_3)
   );

   logic [OBS_W-1:0] obs;
   assign obs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                 mem_enable, mem_wr, mem_addr, mem_data_in, conflict_cnt};

   typedef struct {
      logic             rst;
      logic             if_req;
      logic [31:0]      if_addr;
      logic             d_req;
      logic             d_wr;
      logic [31:0]      d_addr;
      logic [31:0]      d_wdata;
      logic [31:0]      mem_do;
      logic [OBS_W-1:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [OBS_W-1:0] e(
      input logic ig, input logic iv, input logic [31:0] id,
      input logic dg, input logic dv, input logic [31:0] dd,
      input logic en, input logic wr, input logic [31:0] ad,
      input logic [31:0] di, input logic [3:0] cn);
      return {ig, iv, id, dg, dv, dd, en, wr, ad, di, cn};
   endfunction

   function automatic vec_t mk(
      input logic r, input logic ir, input logic [31:0] ia,
      input logic dr, input logic dw, input logic [31:0] da,
      input logic [31:0] dwd, input logic [31:0] mdo, input logic [OBS_W-1:0] ex);
      vec_t v;
      v.rst = r; v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_wr = dw;
      v.d_addr = da; v.d_wdata = dwd; v.mem_do = mdo; v.exp = ex;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst          = v.rst;
      if_req       = v.if_req;
      if_addr      = v.if_addr;
      d_req        = v.d_req;
      d_wr         = v.d_wr;
      d_addr       = v.d_addr;
      d_wdata      = v.d_wdata;
      mem_data_out = v.mem_do;
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_wr = 1'b0;
      d_addr = '0; d_wdata = '0; mem_data_out = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Reference model state for the randomized phase (u_dut, latency 1).
   int          cyc;
   bit          pend_v;
   int          pend_due;
   bit          pend_d;
   bit          m_last_d;
   int          m_cnt;
   bit          ifp, dp, dpw;
   logic [31:0] ia, da, dwd;

   initial begin
      vec_t vecs[17];
      logic [OBS_W-1:0] z;
      logic seen_rv;
      z = '0;

      // Directed vectors, applied one per cycle from reset.
      vecs[0]  = mk(1, 0, 32'h0,  0, 0, 32'h0,  32'h0,        32'h0,        z);
      vecs[1]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        32'hA5A5A5A5, z);
      vecs[2]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        32'hA5A5A5A5, z);
      vecs[3]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        32'hA5A5A5A5, z);
      vecs[4]  = mk(0, 1, 32'h10, 0, 0, 32'h999, 32'h0,       32'h0,
                    e(1, 0, 0, 0, 0, 0, 1, 0, 32'h10, 0, 0));
      vecs[5]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        32'hDEADBEEF,
                    e(0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs[6]  = mk(1, 0, 32'h0,  0, 0, 32'h0,  32'h0,        32'h0,        z);
      vecs[7]  = mk(0, 1, 32'h0,  1, 0, 32'h40, 32'h0,        32'h11111111,
                    e(1, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0));
      vecs[8]  = mk(0, 0, 32'h0,  1, 0, 32'h40, 32'h0,        32'hCAFE0001,
                    e(0, 1, 32'hCAFE0001, 1, 0, 0, 1, 0, 32'h40, 0, 1));
      vecs[9]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        32'h55,
                    e(0, 0, 0, 0, 1, 32'h55, 0, 0, 0, 0, 1));
      for (int i = 10; i < 13; i++)
         vecs[i] = mk(0, 0, 32'h0, 1, 1, 32'h80, 32'h12345678, 32'h77,
                      e(0, 0, 0, 1, 0, 0, 1, 1, 32'h80, 32'h12345678, 1));
      vecs[13] = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        32'hFFFFFFFF,
                    e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs[14] = mk(0, 1, 32'h20, 0, 0, 32'h0,  32'h0,        32'h0,
                    e(1, 0, 0, 0, 0, 0, 1, 0, 32'h20, 0, 1));
      vecs[15] = mk(0, 1, 32'h24, 0, 0, 32'h0,  32'h0,        32'hABCD,
                    e(1, 1, 32'hABCD, 0, 0, 0, 1, 0, 32'h24, 0, 1));
      vecs[16] = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        32'h1234,
                    e(0, 1, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1));

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check($sformatf("vec%0d", i), 256'(obs), 256'(vecs[i].exp));
      end

      // Both requesters held: grants alternate and the counter saturates.
      do_reset();
      for (int i = 0; i < 21; i++) begin
         if (i > 0) @(negedge clk);
         if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h200;
         #1;
         check($sformatf("sat%0d", i), 256'({if_gnt, d_gnt, conflict_cnt}),
               256'({(i % 2) == 0, (i % 2) == 1, 4'((i < 15) ? i : 15)}));
      end

      // Latency 3: load at T, reset at T+1 drops the read.
      do_reset();
      d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h40;
      #1;
      check("lat3_load_gnt", 256'(d_gnt_3), 256'(1));
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      mem_data_out = 32'h9999;
      #1;
      seen_rv = d_rvalid_3 | if_rvalid_3;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         seen_rv = seen_rv | d_rvalid_3 | if_rvalid_3;
      end
      check("lat3_no_rvalid_after_rst", 256'(seen_rv), 256'(0));
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h100;
      #1;
      check("lat3_fetch_gnt", 256'({if_gnt_3, mem_enable_3, mem_addr_3}), 256'({2'b11, 32'h100}));
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         if_req = 1'b0; if_addr = '0;
         mem_data_out = 32'h3333;
         #1;
         check($sformatf("lat3_rv_t%0d", i), 256'({if_rvalid_3, if_rdata_3, d_rvalid_3}),
               256'({i == 3, (i == 3) ? 32'h3333 : 32'h0, 1'b0}));
      end

      // Randomized traffic against a cycle-timestamp model of the rules.
      do_reset();
      pend_v = 0; pend_due = 0; pend_d = 0; m_last_d = 1; m_cnt = 0;
      ifp = 0; dp = 0; dpw = 0; ia = '0; da = '0; dwd = '0;
      for (cyc = 0; cyc < 600; cyc++) begin
         logic rv, free, win_d, any;
         logic [OBS_W-1:0] ex;
         logic [31:0] ex_ird, ex_drd, ex_addr, ex_din;
         logic ex_ig, ex_iv, ex_dg, ex_dv, ex_en, ex_wr;
         if (cyc > 0) @(negedge clk);
         if (!ifp && $urandom_range(0, 2) == 0) begin ifp = 1; ia = $urandom; end
         if (!dp && $urandom_range(0, 2) == 0) begin
            dp = 1; dpw = 1'($urandom_range(0, 1)); da = $urandom; dwd = $urandom;
         end
         if_req = ifp;  if_addr = ifp ? ia : $urandom;
         d_req  = dp;   d_wr = dp ? dpw : 1'($urandom_range(0, 1));
         d_addr = dp ? da : $urandom;  d_wdata = dp ? dwd : $urandom;
         mem_data_out = $urandom;
         #1;
         rv   = pend_v && (pend_due == cyc);
         free = !pend_v || rv;
         any  = free && (ifp || dp);
         win_d = (ifp && dp) ? !m_last_d : dp;
         ex_iv = rv && !pend_d;  ex_ird = ex_iv ? mem_data_out : 32'h0;
         ex_dv = rv && pend_d;   ex_drd = ex_dv ? mem_data_out : 32'h0;
         ex_ig = any && !win_d;
         ex_dg = any && win_d;
         ex_en = any;
         ex_wr = ex_dg && dpw;
         ex_addr = !any ? 32'h0 : (win_d ? da : ia);
         ex_din  = ex_wr ? dwd : 32'h0;
         ex = e(ex_ig, ex_iv, ex_ird, ex_dg, ex_dv, ex_drd, ex_en, ex_wr,
                ex_addr, ex_din, 4'(m_cnt));
         check($sformatf("rand_c%0d", cyc), 256'(obs), 256'(ex));
         if (free && ifp && dp && m_cnt < 15) m_cnt++;
         if (rv) pend_v = 0;
         if (any) begin
            m_last_d = win_d;
            if (!(win_d && dpw)) begin
               pend_v = 1; pend_due = cyc + 1; pend_d = win_d;
            end
            if (win_d) dp = 0; else ifp = 0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares the CPU's single memory port between the instruction-fetch path and the load/store data path. It accepts one request at a time from either requester and drives the memory's enable/write/address/data inputs. It tracks the memory's fixed read latency and returns read data to the requester that owns the outstanding read. It sits between the fetch/decode logic, the ALU load/store path and the `memory` instance.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, memory read latency in cycles (≥1); read data valid on `mem_data_out` MEM_LAT cycles after the issue cycle
- `CNT_W`, 16, width of contention counter

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `if_req`  in  1  fetch read request; held with `if_addr` stable until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  `if_rdata` valid this cycle
- `if_rdata`  out  DATA_W  fetched instruction
- `d_req`  in  1  data request; held with `d_wr`/`d_addr`/`d_wdata` stable until `d_gnt`
- `d_wr`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data request accepted this cycle; for stores, completion
- `d_rvalid`  out  1  `d_rdata` valid this cycle (loads only)
- `d_rdata`  out  DATA_W  load data
- `mem_enable`  out  1  memory access this cycle
- `mem_wr`  out  1  write strobe
- `mem_addr`  out  ADDR_W  memory address
- `mem_data_in`  out  DATA_W  write data to memory
- `mem_data_out`  in  DATA_W  read data from memory
- `conflict_cnt`  out  CNT_W  saturating count of cycles where both requests contended for an issue slot

## Operation
- States: IDLE (port free), RD_WAIT (read outstanding, latency counter running).
- IDLE: if any request is pending, issue one:
  - `*_gnt`=1 and `mem_enable`=1, with the winner's address. For stores, also `mem_wr`=1 and `mem_data_in`=`d_wdata`.
  - Grant and mem outputs are combinational from state, requests and the last-winner flag.
- Arbitration:
  - A single requester wins.
  - If both request, the one not granted last time wins (round-robin via a `last_d` flag).
  - `last_d` resets to 1, so fetch wins the first tie.
  - `last_d` updates on every grant.
- Store: completes in the issue cycle; the state stays IDLE, so the next grant is possible the next cycle.
- Load or fetch: go to RD_WAIT with `lat_cnt`=MEM_LAT and `owner` = the winner.
  - `lat_cnt` decrements each cycle.
  - In the cycle `lat_cnt`=1, the owner's `*_rvalid`=1 and `*_rdata`=`mem_data_out` (pass-through).
  - In that same cycle the FSM behaves as IDLE and may issue a new grant (back-to-back).
- No grants in RD_WAIT except in the final cycle; at most one outstanding read.
- The non-owner's `*_rdata` is 0 and its `*_rvalid` is 0.
- `conflict_cnt` increments in any cycle where the FSM can issue and `if_req`&`d_req`; it saturates at all-ones.
- When nothing is issued: `mem_wr`=0, `mem_addr`=0, `mem_data_in`=0.

## Timing
- Reset values: state IDLE, `lat_cnt`=0, `last_d`=1, `conflict_cnt`=0.
  - All grants, rvalids and mem strobes are 0; all data/address outputs are 0.
- Reset mid-read: the outstanding read is dropped, with no rvalid ever produced; the requester must re-request.
- Read latency: request issued in cycle T → rvalid in cycle T+MEM_LAT.
- Sustained read throughput: one per MEM_LAT cycles. Stores: one per cycle.
- A request arriving during RD_WAIT waits; it is granted no earlier than the rvalid cycle.
- Simultaneous rvalid and new grant is legal. The new grant may go to the same requester, in which case rvalid and gnt are high together.
- A requester dropping its req before gnt is a protocol violation; behaviour is undefined.

## Test plan
- Reset, no requests (MEM_LAT=1) → all outputs 0 for 5 cycles, `conflict_cnt`=0.
- Lone fetch at `if_addr`=0x10, memory returns 0xDEADBEEF → `if_gnt` and `mem_enable` in cycle T with `mem_addr`=0x10, `mem_wr`=0; `if_rvalid`=1 and `if_rdata`=0xDEADBEEF in T+1; `d_rvalid` stays 0.
- Both request from reset (fetch 0x0, load 0x40) → fetch is granted first; load is granted in the fetch's rvalid cycle; `conflict_cnt`=1.
- Store 0x12345678 to 0x80 in back-to-back cycles (3 stores) → `d_gnt`, `mem_wr` and `mem_enable` high for 3 consecutive cycles with `mem_data_in` correct each cycle; no rvalid.
- MEM_LAT=3, load issued at T, `rst` pulsed at T+1 → no `d_rvalid` ever; post-reset, a fresh fetch is granted immediately.
- Hold both requests continuously for 20 issue slots with CNT_W=4 → grants alternate fetch/data; `conflict_cnt` saturates at 15.
